// File: rtl/mdc_output_reorder.sv
// rtl/mdc_output_reorder.sv - ping-pong reorder buffer turning bit-reversed MDC FFT output into natural bin order
module mdc_output_reorder #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         in_first,
  input  logic [W-1:0] in_up_re,
  input  logic [W-1:0] in_up_im,
  input  logic [W-1:0] in_dn_re,
  input  logic [W-1:0] in_dn_im,
  output logic         out_valid,
  output logic [3:0]   out_idx,
  output logic         out_first,
  output logic         out_last,
  output logic [W-1:0] out_a_re,
  output logic [W-1:0] out_a_im,
  output logic [W-1:0] out_b_re,
  output logic [W-1:0] out_b_im,
  output logic         frame_err
);

  typedef enum logic {IDLE = 1'b0, READ = 1'b1} state_t;

  function automatic logic [3:0] rev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  logic [2*W-1:0] mem_a [0:31];
  logic [2*W-1:0] mem_b [0:31];

  logic [3:0] wk;
  logic       wb;
  logic       rb;
  logic [1:0] full;
  logic [3:0] rj;
  state_t     state;
  state_t     state_nxt;
  logic       realign;
  logic       wr_done;
  logic       rd_en;
  logic       rd_last;
  logic [4:0] wr_addr;
  logic [4:0] rd_addr;

  // A stray frame start restarts the current bank at k=0 and drops the partial frame
  assign realign = in_valid && in_first && (wk != 4'd0);
  assign wr_done = in_valid && !realign && (wk == 4'd15);
  assign wr_addr = {wb, realign ? 4'd0 : rev4(wk)};
  assign rd_addr = {rb, rj};

  always_ff @(posedge clk) begin
    if (in_valid) begin
      mem_a[wr_addr] <= {in_up_re, in_up_im};
      mem_b[wr_addr] <= {in_dn_re, in_dn_im};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wk        <= 4'd0;
      wb        <= 1'b0;
      frame_err <= 1'b0;
    end else if (in_valid) begin
      wk        <= realign ? 4'd1 : wk + 4'd1;
      if (wr_done) wb <= ~wb;
      frame_err <= frame_err | realign | (wr_done & full[wb]);
    end
  end

  // Set wins over clear when both sides touch the same bank on one edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 2'b00;
    end else begin
      if (rd_last) full[rb] <= 1'b0;
      if (wr_done) full[wb] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rb <= 1'b0;
      rj <= 4'd0;
    end else begin
      if (rd_last) rb <= ~rb;
      rj <= rd_en ? rj + 4'd1 : 4'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = full[rb] ? READ : IDLE;
      READ:    if (rj == 4'd15) state_nxt = full[~rb] ? READ : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_en   = (state == READ);
    rd_last = (state == READ) && (rj == 4'd15);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_idx   <= 4'd0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_a_re  <= '0;
      out_a_im  <= '0;
      out_b_re  <= '0;
      out_b_im  <= '0;
    end else if (rd_en) begin
      out_valid              <= 1'b1;
      out_idx                <= rj;
      out_first              <= (rj == 4'd0);
      out_last               <= (rj == 4'd15);
      {out_a_re, out_a_im}   <= mem_a[rd_addr];
      {out_b_re, out_b_im}   <= mem_b[rd_addr];
    end else begin
      out_valid <= 1'b0;
      out_idx   <= 4'd0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mdc_output_reorder.sv
// tb/tb_mdc_output_reorder.sv - randomized scoreboard bench for mdc_output_reorder
module tb_mdc_output_reorder;
  localparam int W = 9;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_first = 1'b0;
  logic [W-1:0] in_up_re = '0, in_up_im = '0, in_dn_re = '0, in_dn_im = '0;
  logic         out_valid, out_first, out_last, frame_err;
  logic [3:0]   out_idx;
  logic [W-1:0] out_a_re, out_a_im, out_b_re, out_b_im;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model state
  int pend_re [32];
  int pend_im [32];
  int mk = 0;
  int last_start = -1000;
  int err_exp = 0;
  int exp_re_q [$];
  int exp_im_q [$];
  int start_q [$];

  // monitor state
  int jcnt = 0;
  int cur_start = 0;
  int cur_re [32];
  int cur_im [32];

  mdc_output_reorder #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first),
    .in_up_re(in_up_re), .in_up_im(in_up_im), .in_dn_re(in_dn_re), .in_dn_im(in_dn_im),
    .out_valid(out_valid), .out_idx(out_idx), .out_first(out_first), .out_last(out_last),
    .out_a_re(out_a_re), .out_a_im(out_a_im), .out_b_re(out_b_re), .out_b_im(out_b_im),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int rev4(input int k);
    int r = 0;
    for (int b = 0; b < 4; b++) if (k & (1 << b)) r |= 1 << (3 - b);
    return r;
  endfunction

  // the k-th pair of a frame carries bin rev4(k) and 16+rev4(k); a frame is readable 2 cycles
  // after its last pair, and frames stream no faster than one per 16 cycles
  task automatic model_accept(input int first, input int ure, input int uim, input int dre, input int dim,
                              input int t_edge);
    int st;
    if (first != 0 && mk != 0) begin
      err_exp = 1;
      mk = 0;
    end
    pend_re[rev4(mk)] = ure;      pend_im[rev4(mk)] = uim;
    pend_re[16 + rev4(mk)] = dre; pend_im[16 + rev4(mk)] = dim;
    if (mk == 15) begin
      for (int b = 0; b < 32; b++) begin
        exp_re_q.push_back(pend_re[b]);
        exp_im_q.push_back(pend_im[b]);
      end
      st = (t_edge + 2 > last_start + 16) ? t_edge + 2 : last_start + 16;
      start_q.push_back(st);
      last_start = st;
      mk = 0;
    end else begin
      mk++;
    end
  endtask

  task automatic send(input int first, input int ure, input int uim, input int dre, input int dim);
    in_valid = 1'b1;
    in_first = first[0];
    in_up_re = ure[W-1:0]; in_up_im = uim[W-1:0];
    in_dn_re = dre[W-1:0]; in_dn_im = dim[W-1:0];
    model_accept(first, ure, uim, dre, dim, cyc + 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic int rnd_s();
    return int'($urandom_range(0, 511)) - 256;
  endfunction

  task automatic send_rand_frame(input int gap_max);
    for (int k = 0; k < 16; k++) begin
      send((k == 0) ? int'($urandom_range(0, 1)) : 0, rnd_s(), rnd_s(), rnd_s(), rnd_s());
      if (gap_max > 0) idle(int'($urandom_range(0, gap_max)));
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      if (start_q.size() == 0 && jcnt == 0) break;
      @(negedge clk); #1;
    end
    chk("drain_pending", start_q.size() + jcnt, 0);
  endtask

  task automatic clear_model();
    exp_re_q.delete(); exp_im_q.delete(); start_q.delete();
    mk = 0; last_start = -1000; err_exp = 0; jcnt = 0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (jcnt == 0) begin
          if (start_q.size() == 0) begin
            chk("spurious_valid", start_q.size(), 1);
          end else begin
            cur_start = start_q.pop_front();
            for (int b = 0; b < 32; b++) begin
              cur_re[b] = exp_re_q.pop_front();
              cur_im[b] = exp_im_q.pop_front();
            end
            jcnt = 1;
          end
        end else begin
          jcnt++;
        end
        if (jcnt != 0) begin
          chk("out_time", cyc, cur_start + jcnt - 1);
          chk("out_idx", out_idx, jcnt - 1);
          chk("out_first", out_first, (jcnt == 1) ? 1 : 0);
          chk("out_last", out_last, (jcnt == 16) ? 1 : 0);
          chk("out_a_re", $signed(out_a_re), cur_re[jcnt - 1]);
          chk("out_a_im", $signed(out_a_im), cur_im[jcnt - 1]);
          chk("out_b_re", $signed(out_b_re), cur_re[jcnt + 15]);
          chk("out_b_im", $signed(out_b_im), cur_im[jcnt + 15]);
          if (jcnt == 16) jcnt = 0;
        end
      end else begin
        chk("idle_ctrl", {out_idx, out_first, out_last}, 0);
      end
    end
  end

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_ctrl"}, {out_idx, out_first, out_last}, 0);
    chk({tag, "_a"}, {out_a_re, out_a_im}, 0);
    chk({tag, "_b"}, {out_b_re, out_b_im}, 0);
    chk({tag, "_err"}, frame_err, 0);
  endtask

  initial begin
    int found;
    #1;
    chk_outputs_zero("reset");
    idle(3);
    rst = 1'b0;
    idle(2);

    // single frame with the plan's ramp values
    for (int k = 0; k < 16; k++)
      send((k == 0) ? 1 : 0, rev4(k) + 1, -(rev4(k) + 1), rev4(k) + 17, -(rev4(k) + 17));
    drain();
    chk("err_single", frame_err, err_exp);

    // four back-to-back frames, offset 32n
    for (int n = 0; n < 4; n++)
      for (int k = 0; k < 16; k++)
        send((k == 0) ? 1 : 0, rev4(k) + 1 + 32 * n, -(rev4(k) + 1 + 32 * n),
             rev4(k) + 17 + 32 * n, -(rev4(k) + 17 + 32 * n));
    drain();

    // one idle cycle between every pair
    for (int n = 0; n < 2; n++)
      for (int k = 0; k < 16; k++) begin
        send((k == 0) ? 1 : 0, rnd_s(), rnd_s(), rnd_s(), rnd_s());
        idle(1);
      end
    drain();

    // full-scale extremes
    for (int k = 0; k < 16; k++)
      send((k == 0) ? 1 : 0, (k % 2) ? 255 : -256, (k % 2) ? -256 : 255,
           (k % 3) ? -256 : 255, (k % 3) ? 255 : -256);
    drain();

    // random data with random gaps, optional in_first on k=0
    for (int n = 0; n < 6; n++) send_rand_frame((n % 2) ? 2 : 0);
    drain();
    chk("err_legal", frame_err, err_exp);

    // realignment: 5 stray pairs, then a proper frame
    for (int k = 0; k < 5; k++) send(0, rnd_s(), rnd_s(), rnd_s(), rnd_s());
    for (int k = 0; k < 16; k++) send((k == 0) ? 1 : 0, rnd_s(), rnd_s(), rnd_s(), rnd_s());
    drain();
    chk("err_realign", frame_err, err_exp);
    chk("err_realign_set", frame_err, 1);
    idle(3);
    chk("err_sticky", frame_err, 1);

    // reset in the middle of a readout
    for (int k = 0; k < 16; k++) send((k == 0) ? 1 : 0, rnd_s(), rnd_s(), rnd_s(), rnd_s());
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (out_valid && out_idx == 4'd7) begin
        found = 1;
        break;
      end
    end
    chk("reach_j7", found, 1);
    #2;
    rst = 1'b1;
    #1;
    chk_outputs_zero("midrst");
    clear_model();
    idle(2);
    rst = 1'b0;
    idle(1);
    for (int k = 0; k < 16; k++) send((k == 0) ? 1 : 0, rnd_s(), rnd_s(), rnd_s(), rnd_s());
    drain();
    chk("err_after_rst", frame_err, 0);
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/mdc_output_reorder.md
# mdc_output_reorder

Output reorder buffer for the 32-point radix-2 MDC FFT. It accepts the two bit-reversed output lanes of the final MDC stage, one complex pair per valid cycle. It returns each frame in natural bin order on two lanes: lower half-spectrum (bins 0..15) on lane A and upper half-spectrum (bins 16..31) on lane B. The block sits directly after the last FFT stage and uses a ping-pong buffer of two 16-entry banks per lane, so input and output throughput are identical and no backpressure is needed.

## Interface
- `W`, default 9: signed width of each real/imag component.
- `clk` in 1: single clock; all logic rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: a pair is present on the input lanes this cycle.
- `in_first` in 1: qualifies the first pair (k=0) of a frame; sampled only when `in_valid`=1.
- `in_up_re`, `in_up_im` in W each: MDC upper-lane sample.
- `in_dn_re`, `in_dn_im` in W each: MDC lower-lane sample.
- `out_valid` out 1: output pair valid.
- `out_idx` out 4: natural index j; lane A carries bin j, lane B carries bin j+16.
- `out_first` out 1: high with j=0.
- `out_last` out 1: high with j=15.
- `out_a_re`, `out_a_im` out W each: bin j.
- `out_b_re`, `out_b_im` out W each: bin j+16.
- `frame_err` out 1: sticky; set on a frame realignment or a bank collision; cleared only by `rst`.

## Operation
- **Input order (fixed):**
  - The k-th valid pair of a frame (k=0..15) carries bin rev4(k) on the up lane and bin 16+rev4(k) on the down lane.
  - rev4 is the 4-bit bit reversal, e.g. rev4(1)=8 and rev4(3)=12.
- **Write side:**
  - 4-bit counter `wk` and a write-bank pointer `wb`.
  - On `in_valid`, the up sample is stored at bank `wb`, lane A, address rev4(wk); the down sample is stored at bank `wb`, lane B, address rev4(wk).
  - `wk` increments on each valid pair. When wk=15 is written, `wk` wraps to 0, `wb` toggles, and bank-full flag `full[wb_old]` is set.
  - Gaps (`in_valid`=0) hold `wk`; no write occurs.
- **Realignment:**
  - `in_valid`=1, `in_first`=1 and `wk`≠0: the partial frame is discarded. The pair is written as k=0 into the same bank, `wk`←1, and `frame_err` is set.
  - `in_first`=1 with `wk`=0 is normal.
  - `in_first`=0 with `wk`=0 is accepted as k=0; the first frame after reset needs no `in_first`.
- **Read FSM:**
  - States: IDLE and READ.
  - IDLE→READ when `full[rb]`=1. In READ, read address j runs 0..15, one per cycle, unconditionally.
  - At j=15: `full[rb]` is cleared, `rb` toggles, and the FSM goes to READ again if the new `full[rb]` is set, otherwise to IDLE.
  - Back-to-back frames stream with no idle cycle.
- **Collision:**
  - If a write completes into a bank whose `full` bit is still set, the bank is overwritten, `frame_err` is set, and the read sequence is unaffected.
  - Collision is unreachable with legal input (≥16 cycles per frame) and exists as a guard only.
- **Data path:**
  - Samples pass unmodified; there is no scaling or rounding.
  - Storage is 2 banks × 2 lanes × 16 × 2W bits, as registers or a 1-read/1-write RAM with registered read.

## Timing
- **Reset values:**
  - All outputs are 0, including `frame_err` and data.
  - `wk`=0, `wb`=0, `rb`=0, `full`=00, FSM in IDLE.
- **Latency:** if the pair with k=15 is accepted at edge T, then `out_valid` rises with `out_idx`=0 and `out_first`=1 after edge T+2. Index j appears after edge T+2+j, so `out_last` is high after edge T+17.
- **Output qualification:** outputs are registered. The data lanes hold their last value when `out_valid`=0; `out_idx`, `out_first` and `out_last` are 0 when invalid.
- **Same-cycle bank events:** a bank's final write and the start of its read never address the same bank in the same cycle. When the read releases bank X and the write completes bank X on the same edge, `full[X]` ends at 1, with set taking priority over clear.
- **Reset mid-operation:** `rst` asserted during a write or read aborts immediately. Outputs are 0 on the next evaluation, and both buffered frames are dropped.

## Test plan
- **Single frame:** up = rev4(k)+1, dn = rev4(k)+17, with im = −(re), fed k=0..15 contiguous. Required response: 16 valid cycles starting 2 cycles after the last input, with `out_a_re`=j+1 and `out_b_re`=j+17, `out_first` at j=0, `out_last` at j=15, `frame_err`=0.
- **Back-to-back frames:** 4 frames, 64 contiguous input cycles, frame n offset by 32n. Required response: 64 contiguous `out_valid` cycles, in order, with no gap.
- **Gapped input:** one idle cycle between every pair. Required response: identical output data; each frame bursts 16 cycles, and `out_valid` drops between frames.
- **Realignment:** 5 pairs, then `in_first` with a full frame. Required response: `frame_err`=1, exactly one frame output, and its values belong to the second frame only.
- **Extremes:** inputs of −256 and +255 at W=9. Required response: bit-exact passthrough with sign preserved.
- **Reset mid-read:** assert `rst` at output j=7. Required response: all outputs 0 immediately. A new frame after release produces output with the normal 2-cycle latency, with `rb`=0.
